order_sequencer: RTL

- Front-end controller for the 8-deep shift-window matching engine.
- Collects buy/sell orders from NUM_SRC requesters over valid/ready and round-robin arbitrates them per side.
- Drives the engine's buy/sell price inputs each cycle, inserting neutral fillers (buy 0x00, sell 0xFF) when no order is granted.
- Sequences run/halt/flush of the book; counts trades and records the last trade price from the engine's match output.

---
 rtl/order_seq_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/order_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/order_seq_pkg.sv
// Shared encodings for the order sequencer: controller states, the engine's
// empty-slot marker prices, and the side bit convention on src_side.
package order_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_t;

  // The engine treats these prices as "no order here" in its window.
  localparam logic [7:0] NEUTRAL_BUY  = 8'h00;
  localparam logic [7:0] NEUTRAL_SELL = 8'hFF;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  // True when a price equals the empty marker of its side; such an order is
  // acknowledged but never forwarded or counted.
  function automatic logic is_empty_marker(input logic side, input logic [7:0] price);
    return (side == SIDE_BUY) ? (price == NEUTRAL_BUY) : (price == NEUTRAL_SELL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants at most one requester per cycle, searching from
// the pointer upward with wrap-around. The pointer moves just past the winner
// and holds when nothing is granted. Gating (e.g. "only in RUN") is done by the
// caller masking req.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Rotating priority search and next-pointer computation.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned -- that is what keeps a latch from being inferred.
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Pointer register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/order_sequencer.sv
// Front-end controller for the 8-deep shift-window matching engine. Arbitrates
// buy and sell orders independently, registers the engine price inputs (with
// neutral fillers when idle), sequences IDLE/RUN/FLUSH and keeps trade/accept
// statistics from the engine's match output.
module order_sequencer
  import order_seq_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 flush,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC-1:0]   src_side,
  input  logic [8*NUM_SRC-1:0] src_price,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [7:0]           eng_buy_price,
  output logic [7:0]           eng_sell_price,
  input  logic                 eng_match,
  input  logic [7:0]           eng_trade_price,
  output logic [CNT_W-1:0]     trade_count,
  output logic [CNT_W-1:0]     accept_count,
  output logic [7:0]           last_trade_price,
  output logic [1:0]           state,
  output logic                 busy
);

  localparam int FCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(DEPTH - 1);

  seq_state_t       state_q, state_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic             match_d;

  logic             run_ok;
  logic [NUM_SRC-1:0] buy_req, sell_req, buy_grant, sell_grant;
  logic [7:0]       buy_sel, sell_sel;
  logic             buy_ok, sell_ok, match_rise;
  logic [1:0]       acc_inc;
  logic [CNT_W:0]   acc_sum;
  logic [CNT_W:0]   trade_sum;

  // Orders are taken only in a plain RUN cycle: any command in the same cycle
  // (reset, flush, halt) means the next cycle must already drive neutral.
  assign run_ok   = (state_q == ST_RUN) && !reset && !flush && !halt;
  assign buy_req  = run_ok ? (src_valid &  src_side) : '0;
  assign sell_req = run_ok ? (src_valid & ~src_side) : '0;

  rr_arbiter #(.N(NUM_SRC)) u_buy_arb (
    .clk   (clk),
    .reset (reset),
    .req   (buy_req),
    .grant (buy_grant)
  );

  rr_arbiter #(.N(NUM_SRC)) u_sell_arb (
    .clk   (clk),
    .reset (reset),
    .req   (sell_req),
    .grant (sell_grant)
  );

  assign src_ready = buy_grant | sell_grant;

  // One-hot grant selects the winning price on each side.
  always_comb begin
    buy_sel  = '0;
    sell_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (buy_grant[i])  buy_sel  = buy_sel  | src_price[8*i +: 8];
      if (sell_grant[i]) sell_sel = sell_sel | src_price[8*i +: 8];
    end
  end

  // Empty-marker prices are acknowledged but dropped.
  assign buy_ok  = (|buy_grant)  && !is_empty_marker(SIDE_BUY,  buy_sel);
  assign sell_ok = (|sell_grant) && !is_empty_marker(SIDE_SELL, sell_sel);

  assign acc_inc    = {1'b0, buy_ok} + {1'b0, sell_ok};
  assign acc_sum    = {1'b0, accept_count} + (CNT_W + 1)'(acc_inc);
  assign trade_sum  = {1'b0, trade_count} + (CNT_W + 1)'(1);
  assign match_rise = (state_q == ST_RUN) && eng_match && !match_d;

  // Next-state logic with command priority flush > halt > start.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (flush) begin
      state_d = ST_FLUSH;
      fcnt_d  = FLUSH_LOAD;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_RUN;
        ST_RUN:   if (halt)  state_d = ST_IDLE;
        ST_FLUSH: begin
          if (fcnt_q == '0) state_d = ST_IDLE;
          else              fcnt_d  = fcnt_q - 1'b1;
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State and flush-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Engine price registers, counters and match edge tracking.
  // NOTE: the reset clears every data register here, not just control state,
  // because the counters and engine inputs are architecturally visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      eng_buy_price    <= NEUTRAL_BUY;
      eng_sell_price   <= NEUTRAL_SELL;
      accept_count     <= '0;
      trade_count      <= '0;
      last_trade_price <= '0;
      match_d          <= 1'b0;
    end else begin
      eng_buy_price  <= buy_ok  ? buy_sel  : NEUTRAL_BUY;
      eng_sell_price <= sell_ok ? sell_sel : NEUTRAL_SELL;
      accept_count   <= acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
      match_d        <= eng_match;
      if (match_rise) begin
        trade_count      <= trade_sum[CNT_W] ? '1 : trade_sum[CNT_W-1:0];
        last_trade_price <= eng_trade_price;
      end
    end
  end

  assign state = state_q;
  assign busy  = (state_q != ST_IDLE);

endmodule
